// File: rtl/onchip_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_bridge_pkg
//  Purpose  : Shared constants and types for the on-chip memory burst bridge.
//             Holds the default port widths, the fixed memory read latency
//             and the bridge state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package onchip_bridge_pkg;

    localparam int DEF_ADDR_W   = 15;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_BE_W     = DEF_DATA_W / 8;
    localparam int DEF_BURST_W  = 4;

    // The memory returns data exactly one clock after the address is presented.
    localparam int READ_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WRITE_BURST = 2'd1,
        READ_BURST  = 2'd2
    } state_e;

endpackage : onchip_bridge_pkg
`default_nettype wire

// File: rtl/onchip_burst_addr_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_burst_addr_ctr
//  Purpose  : Loadable word-address counter plus remaining-beat counter for
//             one burst. The load cycle is itself the first beat, so the
//             counters hold the address/count of the *next* beat.
//  Ports    : clk, reset           - clock, synchronous active-high reset
//             i_load               - first beat issued, capture start values
//             i_load_addr          - start word address of the burst
//             i_load_count         - burstcount (0 treated as 1)
//             i_step               - a follow-on beat issued this cycle
//             o_addr_cnt           - address of the next beat
//             o_load_last          - the loading beat is the only beat
//             o_step_last          - the stepping beat is the final beat
//  Revision : 1.0  initial release
// ============================================================================
module onchip_burst_addr_ctr #(
    parameter int ADDR_W  = 15,
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [ADDR_W-1:0]  i_load_addr,
    input  logic [BURST_W-1:0] i_load_count,
    input  logic               i_step,
    output logic [ADDR_W-1:0]  o_addr_cnt,
    output logic               o_load_last,
    output logic               o_step_last
);

    localparam logic [ADDR_W-1:0]  c_addr_one  = ADDR_W'(1);
    localparam logic [BURST_W-1:0] c_burst_one = BURST_W'(1);

    logic [ADDR_W-1:0]  addr_cnt_q, addr_cnt_d;
    logic [BURST_W-1:0] remain_q,   remain_d;
    logic [BURST_W-1:0] w_load_len;

    // A zero burstcount is a single-beat burst.
    assign w_load_len = (i_load_count == '0) ? c_burst_one : i_load_count;

    always_comb begin
        addr_cnt_d = addr_cnt_q;
        remain_d   = remain_q;
        if (i_load) begin
            // Natural modulo-2^ADDR_W wrap from the top word back to zero.
            addr_cnt_d = i_load_addr + c_addr_one;
            remain_d   = w_load_len - c_burst_one;
        end else if (i_step) begin
            addr_cnt_d = addr_cnt_q + c_addr_one;
            remain_d   = remain_q - c_burst_one;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt_q <= '0;
            remain_q   <= '0;
        end else begin
            addr_cnt_q <= addr_cnt_d;
            remain_q   <= remain_d;
        end
    end

    assign o_addr_cnt  = addr_cnt_q;
    assign o_load_last = (w_load_len == c_burst_one);
    assign o_step_last = (remain_q == c_burst_one);

endmodule : onchip_burst_addr_ctr
`default_nettype wire

// File: rtl/onchip_mem_burst_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_mem_burst_bridge
//  Purpose  : Avalon-MM burst slave in front of a single-port on-chip memory
//             with fixed one-cycle read latency. Bursts are split into
//             back-to-back single-word memory accesses, one per clock.
//  Ports    : clk, reset                     - clock, sync active-high reset
//             s_address/s_burstcount         - burst start address, length
//             s_byteenable/s_writedata       - write lanes and data
//             s_read/s_write                 - commands (write has priority)
//             s_waitrequest                  - stall, high during read bursts
//             s_readdata/s_readdatavalid     - read return path
//             m_address/m_byteenable/m_chipselect/m_write/m_writedata
//                                            - memory access port
//             m_clken                        - memory clock enable, tied high
//             m_readdata                     - memory read data
//  Revision : 1.0  initial release
// ============================================================================
module onchip_mem_burst_bridge
    import onchip_bridge_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int BE_W    = DATA_W / 8,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  s_address,
    input  logic [BURST_W-1:0] s_burstcount,
    input  logic [BE_W-1:0]    s_byteenable,
    input  logic               s_read,
    input  logic               s_write,
    input  logic [DATA_W-1:0]  s_writedata,
    output logic               s_waitrequest,
    output logic [DATA_W-1:0]  s_readdata,
    output logic               s_readdatavalid,
    output logic [ADDR_W-1:0]  m_address,
    output logic [BE_W-1:0]    m_byteenable,
    output logic               m_chipselect,
    output logic               m_write,
    output logic [DATA_W-1:0]  m_writedata,
    output logic               m_clken,
    input  logic [DATA_W-1:0]  m_readdata
);

    state_e              state_q, state_d;
    logic                rdv_q,   rdv_d;
    logic                w_load;
    logic                w_step;
    logic                w_load_last;
    logic                w_step_last;
    logic [ADDR_W-1:0]   w_addr_cnt;

    onchip_burst_addr_ctr #(
        .ADDR_W  (ADDR_W),
        .BURST_W (BURST_W)
    ) u_addr_ctr (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_load),
        .i_load_addr  (s_address),
        .i_load_count (s_burstcount),
        .i_step       (w_step),
        .o_addr_cnt   (w_addr_cnt),
        .o_load_last  (w_load_last),
        .o_step_last  (w_step_last)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rdv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdv_q   <= rdv_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and counter control
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        w_load  = 1'b0;
        w_step  = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_write || s_read) begin
                    w_load = 1'b1;
                    if (!w_load_last) begin
                        state_d = s_write ? WRITE_BURST : READ_BURST;
                    end
                end
            end
            WRITE_BURST: begin
                // A low s_write is an upstream bubble: hold position.
                if (s_write) begin
                    w_step = 1'b1;
                    if (w_step_last) begin
                        state_d = IDLE;
                    end
                end
            end
            READ_BURST: begin
                w_step = 1'b1;
                if (w_step_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        m_address     = w_addr_cnt;
        m_byteenable  = '1;
        m_chipselect  = 1'b0;
        m_write       = 1'b0;
        s_waitrequest = 1'b0;
        case (state_q)
            IDLE: begin
                // First beat goes straight through in the accepting cycle.
                m_address = s_address;
                if (s_write) begin
                    m_chipselect = 1'b1;
                    m_write      = 1'b1;
                    m_byteenable = s_byteenable;
                end else if (s_read) begin
                    m_chipselect = 1'b1;
                end
            end
            WRITE_BURST: begin
                m_chipselect = s_write;
                m_write      = s_write;
                m_byteenable = s_byteenable;
            end
            READ_BURST: begin
                m_chipselect  = 1'b1;
                s_waitrequest = 1'b1;
            end
            default: begin
                m_chipselect = 1'b0;
            end
        endcase
        if (reset) begin
            m_chipselect  = 1'b0;
            m_write       = 1'b0;
            s_waitrequest = 1'b1;
        end
        // With a fixed one-cycle memory latency a one-deep valid pipe is
        // all the return path needs.
        rdv_d = m_chipselect & ~m_write;
    end

    assign m_writedata     = s_writedata;
    assign m_clken         = 1'b1;
    assign s_readdata      = m_readdata;
    assign s_readdatavalid = rdv_q & ~reset;

endmodule : onchip_mem_burst_bridge
`default_nettype wire

// File: tb/tb_onchip_mem_burst_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_onchip_mem_burst_bridge
//  Purpose  : Self-checking bench for onchip_mem_burst_bridge with a behavioural
//             one-cycle-latency memory, a shadow memory and scoreboard queues.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_onchip_mem_burst_bridge;

    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 32;
    localparam int BE_W    = 4;
    localparam int BURST_W = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [ADDR_W-1:0]  s_address;
    logic [BURST_W-1:0] s_burstcount;
    logic [BE_W-1:0]    s_byteenable;
    logic               s_read;
    logic               s_write;
    logic [DATA_W-1:0]  s_writedata;
    logic               s_waitrequest;
    logic [DATA_W-1:0]  s_readdata;
    logic               s_readdatavalid;
    logic [ADDR_W-1:0]  m_address;
    logic [BE_W-1:0]    m_byteenable;
    logic               m_chipselect;
    logic               m_write;
    logic [DATA_W-1:0]  m_writedata;
    logic               m_clken;
    logic [DATA_W-1:0]  m_readdata;

    always #5 clk = ~clk;

    onchip_mem_burst_bridge dut (
        .clk             (clk),
        .reset           (reset),
        .s_address       (s_address),
        .s_burstcount    (s_burstcount),
        .s_byteenable    (s_byteenable),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .m_address       (m_address),
        .m_byteenable    (m_byteenable),
        .m_chipselect    (m_chipselect),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_clken         (m_clken),
        .m_readdata      (m_readdata)
    );

    // Behavioural memory: byte-lane writes, registered read data.
    logic [DATA_W-1:0] mem [0:32767];
    logic [DATA_W-1:0] mem_rd_q;
    always @(posedge clk) begin
        if (m_chipselect) begin
            if (m_write) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (m_byteenable[b]) mem[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
                end
            end else begin
                mem_rd_q <= mem[m_address];
            end
        end
    end
    assign m_readdata = mem_rd_q;

    // Scoreboard state
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [BE_W-1:0]   be;
    } wr_t;

    wr_t               wr_q [$];
    logic [ADDR_W-1:0] ra_q [$];
    logic [DATA_W-1:0] rd_q [$];
    logic [DATA_W-1:0] shadow [logic [ADDR_W-1:0]];
    wr_t               mon_e;

    int n_vec = 0;
    int n_fail = 0;
    int wr_count = 0;
    int rdv_total = 0;
    int rdv_run = 0;
    int rdv_run_max = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: got an event with nothing expected, required none", name);
    endtask

    // Monitor: every memory access and every read return is matched against
    // what the stimulus tasks queued.
    always @(negedge clk) begin
        if (!reset) begin
            if (m_chipselect && m_write) begin
                wr_count++;
                if (wr_q.size() == 0) miss("unexpected_write");
                else begin
                    mon_e = wr_q.pop_front();
                    check("wr_addr", 32'(m_address), 32'(mon_e.a));
                    check("wr_data", m_writedata, mon_e.d);
                    check("wr_be", 32'(m_byteenable), 32'(mon_e.be));
                end
            end else if (m_chipselect) begin
                if (ra_q.size() == 0) miss("unexpected_read");
                else check("rd_addr", 32'(m_address), 32'(ra_q.pop_front()));
            end
            if (s_readdatavalid) begin
                rdv_total++;
                rdv_run++;
                if (rdv_run > rdv_run_max) rdv_run_max = rdv_run;
                if (rd_q.size() == 0) miss("unexpected_readdatavalid");
                else check("rd_data", s_readdata, rd_q.pop_front());
            end else begin
                rdv_run = 0;
            end
        end else begin
            rdv_run = 0;
        end
    end

    function automatic logic [DATA_W-1:0] shadow_get(input logic [ADDR_W-1:0] a);
        return shadow.exists(a) ? shadow[a] : '0;
    endfunction

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            s_read  = 1'b0;
            s_write = 1'b0;
        end
    endtask

    // Write burst of n beats; gap_len bubble cycles are inserted before beat
    // index gap_at. Later beats carry a scrambled s_address, which must be ignored.
    task automatic do_write(input logic [ADDR_W-1:0] addr, input int n, input logic [BURST_W-1:0] bc,
                            input logic [BE_W-1:0] be, input logic [DATA_W-1:0] base,
                            input int gap_at, input int gap_len, input bit with_read);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] old;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(posedge clk); #1;
                    s_write = 1'b0;
                    s_read  = 1'b0;
                    @(negedge clk);
                    check("wr_gap_waitrequest", 32'(s_waitrequest), 32'd0);
                end
            end
            @(posedge clk); #1;
            a = ADDR_W'(addr + ADDR_W'(i));
            d = base + DATA_W'(i);
            s_write      = 1'b1;
            s_read       = with_read && (i == 0);
            s_address    = (i == 0) ? addr : ~addr;
            s_burstcount = bc;
            s_byteenable = be;
            s_writedata  = d;
            wr_q.push_back('{a: a, d: d, be: be});
            old = shadow_get(a);
            for (int b = 0; b < BE_W; b++) if (be[b]) old[8*b +: 8] = d[8*b +: 8];
            shadow[a] = old;
            @(negedge clk);
            check("wr_waitrequest", 32'(s_waitrequest), 32'd0);
        end
    endtask

    // Read burst: command cycle, then n-1 stalled issue cycles. Returns after
    // the last issue cycle so a following command lands on the first IDLE cycle.
    task automatic do_read(input logic [ADDR_W-1:0] addr, input int n, input logic [BURST_W-1:0] bc);
        logic [ADDR_W-1:0] a;
        @(posedge clk); #1;
        s_read       = 1'b1;
        s_write      = 1'b0;
        s_address    = addr;
        s_burstcount = bc;
        for (int i = 0; i < n; i++) begin
            a = ADDR_W'(addr + ADDR_W'(i));
            ra_q.push_back(a);
            rd_q.push_back(shadow_get(a));
        end
        @(negedge clk);
        check("rd_accept_waitrequest", 32'(s_waitrequest), 32'd0);
        for (int i = 1; i < n; i++) begin
            @(posedge clk); #1;
            s_read    = 1'b0;
            s_address = ~addr;
            @(negedge clk);
            check("rd_burst_waitrequest", 32'(s_waitrequest), 32'd1);
        end
    endtask

    // Idle until all expected traffic has been seen, with a cycle budget.
    task automatic drain();
        int k;
        k = 0;
        while ((ra_q.size() != 0 || rd_q.size() != 0 || wr_q.size() != 0) && k < 40) begin
            @(posedge clk); #1;
            s_read  = 1'b0;
            s_write = 1'b0;
            @(negedge clk); #1;
            k++;
        end
        check("drain_pending", 32'(ra_q.size() + rd_q.size() + wr_q.size()), 32'd0);
    endtask

    typedef struct {
        bit                 wr;
        logic [ADDR_W-1:0]  addr;
        logic [BURST_W-1:0] bc;
        logic [BE_W-1:0]    be;
        logic [DATA_W-1:0]  data;   // write data, or expected read data
    } vec_t;

    vec_t vecs [7];

    initial begin
        int wc0;
        int rv0;

        vecs[0] = '{wr: 1'b1, addr: 15'h0010, bc: 4'd1, be: 4'hF, data: 32'hDEADBEEF};
        vecs[1] = '{wr: 1'b0, addr: 15'h0010, bc: 4'd1, be: 4'hF, data: 32'hDEADBEEF};
        vecs[2] = '{wr: 1'b1, addr: 15'h0030, bc: 4'd1, be: 4'hF, data: 32'h11223344};
        vecs[3] = '{wr: 1'b1, addr: 15'h0030, bc: 4'd1, be: 4'h3, data: 32'hAABBCCDD};
        vecs[4] = '{wr: 1'b0, addr: 15'h0030, bc: 4'd1, be: 4'hF, data: 32'h1122CCDD};
        vecs[5] = '{wr: 1'b1, addr: 15'h0050, bc: 4'd0, be: 4'hF, data: 32'h5A5A0000};
        vecs[6] = '{wr: 1'b0, addr: 15'h0050, bc: 4'd0, be: 4'hF, data: 32'h5A5A0000};

        reset = 1'b1; s_read = 1'b0; s_write = 1'b0;
        s_address = '0; s_burstcount = '0; s_byteenable = '0; s_writedata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        s_read = 1'b1;              // must be ignored while in reset
        @(negedge clk);
        check("rst_waitrequest", 32'(s_waitrequest), 32'd1);
        check("rst_chipselect", 32'(m_chipselect), 32'd0);
        check("rst_write", 32'(m_write), 32'd0);
        check("rst_readdatavalid", 32'(s_readdatavalid), 32'd0);
        check("rst_clken", 32'(m_clken), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; s_read = 1'b0;
        @(negedge clk);
        check("idle_waitrequest", 32'(s_waitrequest), 32'd0);
        check("idle_chipselect", 32'(m_chipselect), 32'd0);

        // Table-driven single-beat accesses
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].wr) begin
                wc0 = wr_count;
                do_write(vecs[v].addr, 1, vecs[v].bc, vecs[v].be, vecs[v].data, -1, 0, 1'b0);
                drain();
                check($sformatf("vec%0d_write_count", v), 32'(wr_count - wc0), 32'd1);
            end else begin
                do_read(vecs[v].addr, 1, vecs[v].bc);
                @(posedge clk); #1;
                s_read = 1'b0;
                @(negedge clk);
                check($sformatf("vec%0d_rdv", v), 32'(s_readdatavalid), 32'd1);
                check($sformatf("vec%0d_rdata", v), s_readdata, vecs[v].data);
                @(posedge clk); #1;
                @(negedge clk);
                check($sformatf("vec%0d_rdv_after", v), 32'(s_readdatavalid), 32'd0);
                drain();
            end
        end

        // Write burst of 8 with a 2-cycle bubble after the third beat, read back
        wc0 = wr_count;
        do_write(15'h0100, 8, 4'd8, 4'hF, 32'd0, 3, 2, 1'b0);
        drain();
        check("burst8_write_count", 32'(wr_count - wc0), 32'd8);
        rdv_run_max = 0;
        do_read(15'h0100, 8, 4'd8);
        drain();
        check("burst8_rdv_run", 32'(rdv_run_max), 32'd8);

        // Address wrap at the top of memory
        do_write(15'h7FFE, 4, 4'd4, 4'hF, 32'hC0DE0000, -1, 0, 1'b0);
        drain();
        do_read(15'h7FFE, 4, 4'd4);
        drain();

        // Back-to-back read bursts, second accepted on the first IDLE cycle
        do_write(15'h0020, 3, 4'd3, 4'hF, 32'hB0000000, -1, 0, 1'b0);
        do_write(15'h0040, 2, 4'd2, 4'hF, 32'hB1000000, -1, 0, 1'b0);
        drain();
        rdv_run_max = 0;
        do_read(15'h0020, 3, 4'd3);
        do_read(15'h0040, 2, 4'd2);
        drain();
        check("b2b_rdv_run", 32'(rdv_run_max), 32'd5);

        // Simultaneous read and write in IDLE: write wins, no read return
        rv0 = rdv_total;
        wc0 = wr_count;
        do_write(15'h0060, 1, 4'd1, 4'hF, 32'h600DF00D, -1, 0, 1'b1);
        drain();
        check("rw_collide_rdv", 32'(rdv_total - rv0), 32'd0);
        check("rw_collide_write_count", 32'(wr_count - wc0), 32'd1);
        do_read(15'h0060, 1, 4'd1);
        drain();

        // Reset on the second issue cycle of a read burst of 8
        @(posedge clk); #1;
        s_read = 1'b1; s_write = 1'b0; s_address = 15'h0100; s_burstcount = 4'd8;
        ra_q.push_back(15'h0100);
        @(negedge clk);
        check("rstmid_accept_waitrequest", 32'(s_waitrequest), 32'd0);
        @(posedge clk); #1;
        s_read = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("rstmid_chipselect", 32'(m_chipselect), 32'd0);
        check("rstmid_rdv", 32'(s_readdatavalid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_idle_waitrequest", 32'(s_waitrequest), 32'd0);
        check("rstmid_idle_chipselect", 32'(m_chipselect), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstmid_rdv_quiet", 32'(s_readdatavalid), 32'd0);
        end
        do_read(15'h0103, 1, 4'd1);
        drain();
        check("final_rdv_total_nonzero", 32'(rdv_total > 0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule : tb_onchip_mem_burst_bridge
`default_nettype wire
